riscv_mc_ctrl: RTL and testbench

Multicycle control FSM for the RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback by driving the datapath's write enables, mux selects and ALU control, and it handshakes with a shared instruction/data memory port. It sits beside the datapath top module and replaces per-instruction single-cycle decode. It traps on illegal opcodes and on memory timeouts.

---
 rtl/riscv_mc_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_ctrl.sv
// Multicycle control FSM for the RV32I datapath: sequences fetch/decode/
// execute/memory/writeback and traps on illegal opcodes or memory timeouts.
// Optional feature macro: CTRL_INSTRET_EN adds a 32-bit retired-instruction
// counter on port instret.
module riscv_mc_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_src,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [1:0] wb_sel,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state
`ifdef CTRL_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    typedef enum logic [3:0] {
        INIT     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_ALU   = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JAL      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cause_q, cause_d;
    logic [CW-1:0] cnt_q;
    logic          timeout;

    assign timeout = (cnt_q == CNT_LAST);
    assign state   = state_q;

    // Next-state and control decode from the registered state
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        wb_sel     = 2'b00;
        trap       = 1'b0;
        trap_cause = 2'b00;
        case (state_q)
            INIT: state_d = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    alu_src_b = 2'b01;
                    state_d   = DECODE;
                end else if (timeout) begin
                    state_d = TRAP;
                    cause_d = 2'b10;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                if (opcode == 7'b0110011)
                    state_d = EXEC_R;
                else if (opcode == 7'b0010011)
                    state_d = EXEC_I;
                else if ((opcode == 7'b0000011 || opcode == 7'b0100011) && funct3 == 3'b010)
                    state_d = MEM_ADDR;
                else if (opcode == 7'b1100011 && funct3 == 3'b000)
                    state_d = BRANCH;
                else if (opcode == 7'b1101111)
                    state_d = JAL;
                else begin
                    state_d = TRAP;
                    cause_d = 2'b01;
                end
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                state_d   = WB_ALU;
                case ({funct3, funct7_5})
                    4'b000_0: alu_ctrl = ALU_ADD;
                    4'b000_1: alu_ctrl = ALU_SUB;
                    4'b111_0: alu_ctrl = ALU_AND;
                    4'b110_0: alu_ctrl = ALU_OR;
                    4'b010_0: alu_ctrl = ALU_SLT;
                    default: begin
                        state_d = TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                state_d   = WB_ALU;
                case (funct3)
                    3'b000:  alu_ctrl = ALU_ADD;
                    3'b111:  alu_ctrl = ALU_AND;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b010:  alu_ctrl = ALU_SLT;
                    default: begin
                        state_d = TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                state_d   = (opcode == 7'b0100011) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                if (mem_ready)
                    state_d = WB_MEM;
                else if (timeout) begin
                    state_d = TRAP;
                    cause_d = 2'b10;
                end
            end
            MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_src = 1'b1;
                if (mem_ready)
                    state_d = FETCH;
                else if (timeout) begin
                    state_d = TRAP;
                    cause_d = 2'b10;
                end
            end
            WB_ALU: begin
                reg_we  = 1'b1;
                state_d = FETCH;
            end
            WB_MEM: begin
                reg_we  = 1'b1;
                wb_sel  = 2'b01;
                state_d = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                pc_we     = zero;
                state_d   = FETCH;
            end
            JAL: begin
                reg_we  = 1'b1;
                wb_sel  = 2'b10;
                pc_we   = 1'b1;
                state_d = FETCH;
            end
            TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: state_d = INIT;
        endcase
    end

    // State, trap cause and memory wait counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= INIT;
            cause_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_d != state_q && (state_d == FETCH || state_d == MEM_RD || state_d == MEM_WR))
                cnt_q <= '0;
            else if (mem_req && !mem_ready && !timeout)
                cnt_q <= cnt_q + CW'(1);
        end
    end

`ifdef CTRL_INSTRET_EN
    logic [31:0] instret_q;
    assign instret = instret_q;

    // Count instructions retiring back into FETCH
    always_ff @(posedge clk) begin
        if (!rst)
            instret_q <= 32'd0;
        else if (state_d == FETCH &&
                 (state_q == WB_ALU || state_q == WB_MEM || state_q == MEM_WR ||
                  state_q == BRANCH || state_q == JAL))
            instret_q <= instret_q + 32'd1;
    end
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Randomized bench for riscv_mc_ctrl: each instruction is expanded into its
// expected per-cycle state/mem_ready trace and all outputs are compared.
module tb_riscv_mc_ctrl;

    localparam int unsigned TO = 16;

    localparam logic [3:0] S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
        S_EXR = 4'd3, S_EXI = 4'd4, S_MADDR = 4'd5, S_MRD = 4'd6, S_MWR = 4'd7,
        S_WBA = 4'd8, S_WBM = 4'd9, S_BR = 4'd10, S_JAL = 4'd11, S_TRAP = 4'd12;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
        OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5, zero, mem_ready;
    logic       mem_req, mem_we, addr_src, ir_we, pc_we, reg_we;
    logic [1:0] alu_src_a, alu_src_b, wb_sel, trap_cause;
    logic [3:0] alu_ctrl, state;
    logic       trap;
`ifdef CTRL_INSTRET_EN
    logic [31:0] instret;
`endif

    riscv_mc_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_src(addr_src), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause), .state(state)
`ifdef CTRL_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic [1:0] cause;
    } cyc_t;

    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Spec ALU mapping: {legal, code}
    function automatic logic [4:0] r_alu(input logic [2:0] f3, input logic f7);
        case ({f3, f7})
            4'b000_0: return 5'b1_0000;
            4'b000_1: return 5'b1_0001;
            4'b111_0: return 5'b1_0010;
            4'b110_0: return 5'b1_0011;
            4'b010_0: return 5'b1_0100;
            default:  return 5'b0_0000;
        endcase
    endfunction

    function automatic logic [4:0] i_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return 5'b1_0000;
            3'b111:  return 5'b1_0010;
            3'b110:  return 5'b1_0011;
            3'b010:  return 5'b1_0100;
            default: return 5'b0_0000;
        endcase
    endfunction

    // Packed expected outputs:
    // {mem_req,mem_we,addr_src,ir_we,pc_we,reg_we,src_a,src_b,alu,wb,trap,cause}
    function automatic logic [18:0] exp_outs(input cyc_t c);
        logic mr = 0, mw = 0, as = 0, iw = 0, pw = 0, rw = 0, tr = 0;
        logic [1:0] sa = 0, sb = 0, wb = 0, cs = 0;
        logic [3:0] ac = 0;
        case (c.st)
            S_FETCH: begin mr = 1; if (c.rdy) begin iw = 1; pw = 1; sb = 2'b01; end end
            S_DECODE: begin sa = 2'b01; sb = 2'b10; end
            S_EXR: begin sa = 2'b10; ac = r_alu(funct3, funct7_5) & 5'h0F; end
            S_EXI: begin sa = 2'b10; sb = 2'b10; ac = i_alu(funct3) & 5'h0F; end
            S_MADDR: begin sa = 2'b10; sb = 2'b10; end
            S_MRD: begin mr = 1; as = 1; end
            S_MWR: begin mr = 1; mw = 1; as = 1; end
            S_WBA: rw = 1;
            S_WBM: begin rw = 1; wb = 2'b01; end
            S_BR: begin sa = 2'b10; ac = 4'b0001; pw = zero; end
            S_JAL: begin rw = 1; wb = 2'b10; pw = 1; end
            S_TRAP: begin tr = 1; cs = c.cause; end
            default: ;
        endcase
        return {mr, mw, as, iw, pw, rw, sa, sb, ac, wb, tr, cs};
    endfunction

    function automatic logic [18:0] dut_outs();
        return {mem_req, mem_we, addr_src, ir_we, pc_we, reg_we, alu_src_a, alu_src_b,
                alu_ctrl, wb_sel, trap, trap_cause};
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy, input logic [1:0] cause);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.cause = cause;
        q.push_back(c);
    endtask

    // Memory phase with w wait cycles; w >= TO means the access times out
    task automatic add_mem(input logic [3:0] st, input int w, output bit timed_out);
        timed_out = (w >= int'(TO));
        for (int i = 0; i < (timed_out ? int'(TO) : w); i++) push(st, 1'b0, 2'b00);
        if (!timed_out) push(st, 1'b1, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'($urandom);
        @(negedge clk);
        #1;
        check("reset_state", 32'(state), 32'(S_INIT));
        check("reset_outs", 32'(dut_outs()), 32'd0);
`ifdef CTRL_INSTRET_EN
        check("reset_instret", instret, 32'd0);
`endif
        rst = 1'b1;
    endtask

    // Build the expected trace of one instruction, play it, reset after a trap or abort
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int wf, input int wm, input int hold,
                             input int abort_at);
        bit to;
        bit trapped = 0;
        logic [1:0] cause = 2'b00;
        int n;
        q.delete();
        opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
        add_mem(S_FETCH, wf, to);
        if (to) begin trapped = 1; cause = 2'b10; end
        else begin
            push(S_DECODE, 1'($urandom), 2'b00);
            if (op == OP_R || op == OP_I) begin
                push(op == OP_R ? S_EXR : S_EXI, 1'($urandom), 2'b00);
                if ((op == OP_R ? r_alu(f3, f7) : i_alu(f3)) >> 4) push(S_WBA, 1'($urandom), 2'b00);
                else begin trapped = 1; cause = 2'b01; end
            end else if ((op == OP_LD || op == OP_ST) && f3 == 3'b010) begin
                push(S_MADDR, 1'($urandom), 2'b00);
                add_mem(op == OP_LD ? S_MRD : S_MWR, wm, to);
                if (to) begin trapped = 1; cause = 2'b10; end
                else if (op == OP_LD) push(S_WBM, 1'($urandom), 2'b00);
            end else if (op == OP_BR && f3 == 3'b000) push(S_BR, 1'($urandom), 2'b00);
            else if (op == OP_JAL) push(S_JAL, 1'($urandom), 2'b00);
            else begin trapped = 1; cause = 2'b01; end
        end
        if (trapped) for (int i = 0; i < hold; i++) push(S_TRAP, 1'($urandom), cause);
        n = (abort_at > 0 && abort_at < q.size()) ? abort_at : q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_ready = q[i].rdy;
            #1;
            check("state", 32'(state), 32'(q[i].st));
            check("outs", 32'(dut_outs()), 32'(exp_outs(q[i])));
        end
        if (trapped || n < q.size()) do_reset();
    endtask

    logic [6:0] ops[6];

    initial begin
        int k, f3r, wf, wm;
        logic [6:0] op;
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD;
        ops[3] = OP_ST; ops[4] = OP_BR; ops[5] = OP_JAL;
        rst = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        do_reset();

        // add x7,x1,x2 (0x002083B3), then lw with 3 wait cycles, beq taken / not taken
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0);
        run_instr(OP_LD, 3'b010, 1'b0, 1'b0, 0, 3, 0, 0);
        run_instr(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0, 0, 0);
        run_instr(OP_BR, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0);
        run_instr(OP_ST, 3'b010, 1'b0, 1'b0, 0, 0, 0, 0);
        run_instr(OP_JAL, 3'b101, 1'b1, 1'b0, 0, 0, 0, 0);
        // mem_ready arriving exactly at the last allowed wait cycle wins over timeout
        run_instr(OP_I, 3'b000, 1'b0, 1'b0, TO - 1, 0, 0, 0);
        run_instr(OP_LD, 3'b010, 1'b0, 1'b0, 0, TO - 1, 0, 0);
        // illegal opcode held in TRAP for 20 cycles, fetch and load timeouts
        run_instr(7'h7F, 3'b000, 1'b0, 1'b0, 0, 0, 20, 0);
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, TO, 0, 3, 0);
        run_instr(OP_LD, 3'b010, 1'b0, 1'b0, 0, TO, 3, 0);
        run_instr(OP_ST, 3'b010, 1'b0, 1'b0, 1, TO, 3, 0);

`ifdef CTRL_INSTRET_EN
        @(negedge clk);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        run_instr(OP_I, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("instret_wrap", instret, 32'd0);
        do_reset();
`endif

        for (int t = 0; t < 200; t++) begin
            k = $urandom_range(0, 9);
            op = (k < 6) ? ops[k] : 7'($urandom);
            f3r = $urandom_range(0, 3);
            funct3 = 3'($urandom);
            if (f3r != 0 && (op == OP_LD || op == OP_ST)) funct3 = 3'b010;
            if (f3r != 0 && op == OP_BR) funct3 = 3'b000;
            wf = ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 2, TO) : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO) : $urandom_range(0, 3);
            run_instr(op, funct3, ($urandom_range(0, 3) == 0), 1'($urandom), wf, wm,
                      $urandom_range(1, 5),
                      ($urandom_range(0, 14) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
